// File: rtl/phase_accum_nco.sv
// phase_accum_nco
// Multi-channel phase-accumulator oscillator for the ADPLL DCO stage.
// Each channel adds its active control code to an ACC_WIDTH-bit accumulator
// every enabled cycle, giving f_out = k * f_clk / 2^ACC_WIDTH. The MSB of the
// accumulator is the oscillator clock, a carry out is a one-cycle wrap pulse.
//
// Code-write handshake: a write is accepted on a rising edge of fpga_clk_i
// when k_valid_i and k_ready_o are both high. k_ready_o is a combinational
// function of k_chan_i and the selected channel's pending flag only (it does
// not depend on k_valid_i). A channel holding a deferred code deasserts ready
// until that code commits at its next wrap. Writes to a channel index at or
// above CHANNELS see ready high and are silently dropped.
module phase_accum_nco #(
    parameter int                 ACC_WIDTH = 16,
    parameter int                 K_WIDTH   = 16,
    parameter int                 CHANNELS  = 2,
    parameter logic [K_WIDTH-1:0] K_RESET   = '0,
    localparam int                CW        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                          fpga_clk_i,
    input  logic                          reset_n_i,
    input  logic [CHANNELS-1:0]           enable_i,
    input  logic [CHANNELS-1:0]           phase_clr_i,
    input  logic [K_WIDTH-1:0]            k_val_i,
    input  logic [CW-1:0]                 k_chan_i,
    input  logic                          k_mode_i,
    input  logic                          k_valid_i,
    output logic                          k_ready_o,
    output logic [CHANNELS-1:0]           clk_o,
    output logic [CHANNELS-1:0]           wrap_o,
    output logic [CHANNELS*ACC_WIDTH-1:0] phase_o
);

    // Zero-extension width for the control code inside the ACC_WIDTH+1 adder.
    localparam int K_PAD = ACC_WIDTH + 1 - K_WIDTH;

    // Pending flag per channel, gathered so the ready mux can see all of them.
    logic [CHANNELS-1:0] pend;
    // One-hot accepted-write strobe per channel.
    logic [CHANNELS-1:0] wr_sel;

    // Ready: inverse of the addressed channel's pending flag; out-of-range is always ready.
    always_comb begin
        k_ready_o = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (int'(k_chan_i) == c) begin
                k_ready_o = ~pend[c];
            end
        end
    end

    // Decode an accepted write to its target channel (nothing selected when out of range).
    always_comb begin
        wr_sel = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            wr_sel[c] = k_valid_i && (int'(k_chan_i) == c) && !pend[c];
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        logic [ACC_WIDTH-1:0] acc;
        logic                 wrap_q;
        logic [K_WIDTH-1:0]   k_act;
        logic [K_WIDTH-1:0]   k_pend;
        logic                 pend_q;
        logic [ACC_WIDTH:0]   sum;
        logic                 carry;
        logic                 step;
        logic                 commit;

        // Widened add so the carry out of the accumulator is the wrap event.
        always_comb begin
            sum   = {1'b0, acc} + {{K_PAD{1'b0}}, k_act};
            carry = sum[ACC_WIDTH];
        end

        // A channel advances only when enabled and not being cleared; a deferred
        // code commits on the same edge that overflows, so the wrapping add itself
        // still uses the old code.
        always_comb begin
            step   = enable_i[c] && !phase_clr_i[c];
            commit = step && carry && pend_q;
        end

        // Accumulator and registered wrap pulse: clear beats step beats hold.
        always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                acc    <= '0;
                wrap_q <= 1'b0;
            end else if (phase_clr_i[c]) begin
                acc    <= '0;
                wrap_q <= 1'b0;
            end else if (enable_i[c]) begin
                acc    <= sum[ACC_WIDTH-1:0];
                wrap_q <= carry;
            end else begin
                wrap_q <= 1'b0;
            end
        end

        // Control code registers: wrap commit of a deferred code, or an accepted write.
        // A write is only accepted while pend_q is low and a commit needs pend_q high,
        // so the two branches can never be live on the same edge.
        always_ff @(posedge fpga_clk_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                k_act  <= K_RESET;
                k_pend <= '0;
                pend_q <= 1'b0;
            end else if (commit) begin
                k_act  <= k_pend;
                pend_q <= 1'b0;
            end else if (wr_sel[c]) begin
                if (k_mode_i) begin
                    k_act <= k_val_i;
                end else begin
                    k_pend <= k_val_i;
                    pend_q <= 1'b1;
                end
            end
        end

        assign pend[c]                            = pend_q;
        assign clk_o[c]                           = acc[ACC_WIDTH-1];
        assign wrap_o[c]                          = wrap_q;
        assign phase_o[c*ACC_WIDTH +: ACC_WIDTH]  = acc;
    end

endmodule

// File: doc/phase_accum_nco.md
# phase_accum_nco

Multi-channel, parametrised phase-accumulator oscillator for the ADPLL's digitally controlled oscillator stage. Each channel runs an ACC_WIDTH-bit accumulator stepped by its own control code, giving output frequency k·f_clk/2^ACC_WIDTH. New control codes arrive over a valid/ready handshake and apply either immediately or glitch-free at the channel's next wrap. Each channel also exposes a per-wrap pulse and its full phase word for the loop filter and phase detector.

## Interface
- ACC_WIDTH, 16, accumulator width in bits; clk_o is its MSB.
- K_WIDTH, 16, control code width; K_WIDTH ≤ ACC_WIDTH, zero-extended.
- CHANNELS, 2, number of independent accumulators; ≥ 1.
- K_RESET, 0, active control code of every channel after reset.
- CW, max(1, clog2(CHANNELS)), channel-select width; derived, not overridden.

- fpga_clk_i  in  1  single clock, rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- enable_i  in  CHANNELS  per-channel run enable.
- phase_clr_i  in  CHANNELS  per-channel synchronous accumulator clear.
- k_val_i  in  K_WIDTH  new control code; larger value gives higher frequency.
- k_chan_i  in  CW  target channel for k_val_i.
- k_mode_i  in  1  0 = deferred (apply at next wrap), 1 = immediate.
- k_valid_i  in  1  code-write request.
- k_ready_o  out  1  write accepted when k_valid_i & k_ready_o at a clock edge.
- clk_o  out  CHANNELS  accumulator MSB per channel.
- wrap_o  out  CHANNELS  one-cycle pulse per accumulator overflow.
- phase_o  out  CHANNELS·ACC_WIDTH  accumulator values; channel c occupies bits [c·ACC_WIDTH +: ACC_WIDTH].

## Operation
- Per-channel state: acc[c] (ACC_WIDTH), k_act[c] (K_WIDTH), k_pend[c] (K_WIDTH), pend[c] (1 bit).
- Sum: {carry, sum} = acc[c] + zero-extended k_act[c], computed ACC_WIDTH+1 bits wide. Wrap is carry = 1. Arithmetic is modulo 2^ACC_WIDTH.
- Per-channel priority at each edge:
  1. phase_clr_i[c]: acc ← 0, wrap_o ← 0. A pending code is not committed.
  2. enable_i[c]: acc ← sum, wrap_o ← carry. If carry = 1 and pend = 1, then k_act ← k_pend and pend ← 0.
  3. Otherwise: acc holds, wrap_o ← 0.
- k_ready_o = ~pend[k_chan_i], combinational. It is 1 when k_chan_i ≥ CHANNELS; writes to such a channel are discarded.
- Accepted write with k_mode_i = 1: k_act[k_chan_i] ← k_val_i.
- Accepted write with k_mode_i = 0: k_pend ← k_val_i, pend ← 1.
- A channel with pend = 1 accepts no further writes, immediate or deferred, until its pending code commits.
- A disabled channel never wraps, so its pending code stays pending indefinitely.
- k_act = 0 with enable = 1: acc holds, no wrap.

## Timing
- Reset (async assert, sync-safe deassert by the system):
  - acc = 0, k_act = K_RESET, pend = 0.
  - clk_o = 0, wrap_o = 0, phase_o = 0.
  - k_ready_o = 1.
  - Reset mid-operation discards pending codes immediately.
- clk_o and phase_o come directly from registers: zero combinational latency after the edge.
- wrap_o is registered. It is high exactly during the cycle in which phase_o shows the post-wrap value.
- Immediate write accepted at edge N: the add at edge N uses the old k_act. The first add using the new code is at edge N+1.
- Deferred commit at wrap edge W: the add at edge W uses the old code. The new code applies from edge W+1. pend clears at W, so k_ready_o rises in cycle W (after the edge).
- Commit at edge W and a new write to the same channel at edge W cannot coincide, because ready is low at W.
- Writes to different channels and commits are fully independent in the same cycle.

## Test plan
Parameters for all scenarios: ACC_WIDTH = 4, K_WIDTH = 4, CHANNELS = 2, K_RESET = 0.

- **Basic frequency:** reset, immediate write k = 1 to ch0, enable_i = 01 → phase_o[0] steps 1, 2, …, 15, 0; clk_o[0] is 8 cycles low / 8 high; wrap_o[0] pulses every 16 cycles; ch1 stays 0.
- **Immediate step:** immediate write k = 4 to ch1 with ch1 enabled → one add at the old code (0), then phase 4, 8, 12, 0 repeating; wrap_o[1] every 4th cycle; clk_o[1] is 50% duty at period 4.
- **Deferred commit:**
  - Setup: ch0 running k = 1 at phase 5; deferred write k = 8.
  - During the wait: k_ready_o drops (k_chan_i = 0), and phase continues 6 … 15.
  - At the wrap: phase goes to 0 with wrap_o pulse, then 8, 0, 8.
  - k_ready_o returns to 1 in the cycle phase = 0.
- **Enable and clear:**
  - Setup: ch0 has a pending code; drop enable_i[0] at phase 9.
  - While disabled: phase holds at 9, no wrap_o, pend stays set.
  - Pulse phase_clr_i[0] → phase 0, pending still not committed.
  - Re-enable → phase resumes stepping, and the pending code commits only at the next overflow.
- **Out-of-range channel:** k_chan_i = 1 with CHANNELS = 1 build, valid high → k_ready_o = 1, no state change.
- **Async reset mid-run:** assert reset_n_i low between edges with both channels running and one code pending → all outputs 0 immediately without a clock edge, k_ready_o = 1; after release, k_act = 0 and nothing advances.
